i2s_tx_param: RTL
=================

// Module: i2s_tx_param
// PURPOSE
// - Parametrised stereo I2S transmitter driving the DAC from the 12.288 MHz input_clk domain.
// - Derives serial_clk/word_select, forwards dac_mclk, serialises L/R samples MSB-first.
// - Accepts samples through a one-deep valid/ready buffer; mutes and flags on underrun.
// - Successor to the fixed-tone sound test: parametrised widths/ratio, real sample path.
// PARAMETERS
// - SAMPLE_BITS  24  audio bits per channel; 1..SLOT_BITS
// - SLOT_BITS    32  SCLK periods per channel slot; frame = 2*SLOT_BITS
// - SCLK_DIV     2   input_clk cycles per serial_clk half-period; >=1 (2 -> 3.072 MHz, fs 48 kHz)
// PORTS
// - input_clk      in   1               master clock; all state on its rising edge
// - reset          in   1               async assert, active-low; deassert sync to input_clk
// - sample_l       in   SAMPLE_BITS     left sample, two's complement
// - sample_r       in   SAMPLE_BITS     right sample, two's complement
// - sample_valid   in   1               sample_l/r valid
// - sample_ready   out  1               holding buffer empty
// - dac_mclk       out  1               = input_clk (combinational forward)
// - serial_clk     out  1               bit clock; DAC samples on rising edge
// - word_select    out  1               0 = left slot, 1 = right slot
// - sound_bit_out  out  1               serial data
// - bit_counter    out  $clog2(2*SLOT_BITS)  frame bit position b
// - frame_start    out  1               1-cycle pulse when b wraps to 0
// - underrun       out  1               1-cycle pulse: frame loaded with empty buffer
// BEHAVIOUR
// - Reset values: serial_clk=0, word_select=1, sound_bit_out=0, bit_counter=2*SLOT_BITS-1,
//   sample_ready=1, frame_start=0, underrun=0, div counter=0, buffers/active frame=0.
// - Divider counts 0..SCLK_DIV-1; at terminal count serial_clk toggles, counter -> 0.
// - "Fall edge" = input_clk edge where serial_clk goes 1->0. Only there: b increments
//   (2*SLOT_BITS-1 wraps to 0); word_select, sound_bit_out update in same registered edge.
//   Data thus stable SCLK_DIV input_clk cycles before each serial_clk rise.
// - word_select = 0 for b in [0,SLOT_BITS-1], 1 for b in [SLOT_BITS,2*SLOT_BITS-1].
// - I2S one-bit delay: left bit i (MSB=SAMPLE_BITS-1) at b=SAMPLE_BITS-i; right bit i at
//   b=SLOT_BITS+SAMPLE_BITS-i; b=0 carries previous frame's right LSB if
//   SAMPLE_BITS==SLOT_BITS; every other unused position outputs 0.
// - Handshake: transfer when sample_valid&&sample_ready on rising input_clk; buffer full,
//   sample_ready=0 next cycle. Data must be held while valid&&!ready.
// - Frame load on the fall edge where b wraps to 0: buffer -> active frame, sample_ready=1
//   next cycle, frame_start pulses. Buffer empty -> active frame=0 (mute), underrun pulses.
// - Simultaneous accept and frame load: accepted sample enters active frame directly,
//   buffer stays empty, sample_ready stays 1, no underrun.
// - Reset mid-frame: all outputs return to reset values immediately; pending sample lost.
// CONFIGURATION
// - I2S_TX_LJ_EN defined: left-justified format; no one-bit delay: left bit i at
//   b=SAMPLE_BITS-1-i, right bit i at b=SLOT_BITS+SAMPLE_BITS-1-i; b=0 carries left MSB.
//   Word_select timing, handshake, underrun unchanged.
// - Undefined: standard I2S timing above.
// TESTING
// - Reset low 3 cycles -> all outputs at reset values, dac_mclk toggles with input_clk.
// - Defaults, no samples: serial_clk period 4 input_clk; WS 32 SCLK low/32 high; underrun
//   pulse every 256 input_clk; sound_bit_out constant 0.
// - Feed L=24'hA5A5A5, R=24'h5A5A5A each frame -> decode at serial_clk rise from b=1 /
//   b=33 yields A5A5A5 / 5A5A5A; b=25..32 and 57..0 read 0; no underrun.
// - Hold sample_valid high continuously -> one accept per frame; sample_ready low between
//   frame loads; no sample dropped or repeated over 10 frames.
// - Assert valid on exact frame-load cycle with empty buffer -> sample output this frame,
//   underrun=0, sample_ready remains 1.
// - SAMPLE_BITS=SLOT_BITS=16, SCLK_DIV=1 and I2S_TX_LJ_EN -> right LSB at b=0 (I2S),
//   left MSB at b=0 (LJ); reset asserted at b=20 -> outputs at reset values same cycle.

Source files
------------

// File: rtl/i2s_tx_param_if.sv
// rtl/i2s_tx_param_if.sv - sample handshake interface for i2s_tx_param
// Purpose: carries one stereo sample pair plus its valid/ready handshake.
// Signals:
//   sample_l, sample_r  SAMPLE_BITS  two's complement left/right sample (source -> tx)
//   sample_valid        1            sample_l/r valid (source -> tx)
//   sample_ready        1            transmitter holding buffer empty (tx -> source)
// Modports: master = sample source, slave = transmitter.
interface i2s_tx_param_if #(
  parameter int SAMPLE_BITS = 24
);
  logic [SAMPLE_BITS-1:0] sample_l;
  logic [SAMPLE_BITS-1:0] sample_r;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx_param.sv
// rtl/i2s_tx_param.sv - parametrised stereo I2S transmitter with one-deep sample buffer
// Purpose: derives serial_clk/word_select from input_clk, forwards dac_mclk, and
//   serialises L/R samples MSB-first; mutes the frame and pulses underrun when no
//   sample is available at frame load.
// Configuration: define I2S_TX_LJ_EN for left-justified data (no one-bit delay);
//   undefined gives standard I2S timing.
// Ports:
//   input_clk      in   master clock, all state on its rising edge
//   reset          in   async assert, active-low
//   smp            slave modport: sample_l/sample_r/sample_valid in, sample_ready out
//   dac_mclk       out  combinational copy of input_clk
//   serial_clk     out  bit clock, DAC samples on its rising edge
//   word_select    out  0 = left slot, 1 = right slot
//   sound_bit_out  out  serial data
//   bit_counter    out  frame bit position b
//   frame_start    out  1-cycle pulse when b wraps to 0
//   underrun       out  1-cycle pulse when a frame is loaded from an empty buffer
module i2s_tx_param #(
  parameter int SAMPLE_BITS = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SCLK_DIV    = 2
) (
  input  logic                            input_clk,
  input  logic                            reset,
  i2s_tx_param_if.slave                   smp,
  output logic                            dac_mclk,
  output logic                            serial_clk,
  output logic                            word_select,
  output logic                            sound_bit_out,
  output logic [$clog2(2*SLOT_BITS)-1:0]  bit_counter,
  output logic                            frame_start,
  output logic                            underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [BW-1:0]          B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [DW-1:0]          DIV_LAST = DW'(SCLK_DIV - 1);
  // Bit-position arithmetic is done one bit wider than b so SLOT+SAMPLE fits.
  localparam logic [BW:0]            C_ONE    = (BW+1)'(1);
  localparam logic [BW:0]            C_SB     = (BW+1)'(SAMPLE_BITS);
  localparam logic [BW:0]            C_SLOT   = (BW+1)'(SLOT_BITS);
  localparam logic [SAMPLE_BITS-1:0] LSB_ONE  = SAMPLE_BITS'(1);

  logic [DW-1:0]          div_q, div_d;
  logic                   sclk_q, sclk_d;
  logic                   ws_q, ws_d;
  logic                   sd_q, sd_d;
  logic [BW-1:0]          b_q, b_d;
  logic                   buf_full_q, buf_full_d;
  logic [SAMPLE_BITS-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_BITS-1:0] buf_r_q, buf_r_d;
  logic [SAMPLE_BITS-1:0] act_l_q, act_l_d;
  logic [SAMPLE_BITS-1:0] act_r_q, act_r_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;

  logic                   tc;
  logic                   fall;
  logic                   wrap;
  logic                   accept;
  logic [BW-1:0]          b_next;
  logic [BW:0]            b_ext;
  logic [BW:0]            idx_l, idx_r;
  logic [SAMPLE_BITS-1:0] load_l, load_r;
  logic [SAMPLE_BITS-1:0] src_l, src_r;
  logic                   bit_l, bit_r;
  logic                   next_bit;

  // Divider and bit position.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    tc     = (div_q == DIV_LAST);
    if (tc) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end
    fall   = tc & sclk_q;
    wrap   = fall & (b_q == B_LAST);
    b_next = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    b_d    = fall ? b_next : b_q;
    b_ext  = {1'b0, b_next};
    ws_d   = fall ? (b_ext >= C_SLOT) : ws_q;
  end

  // Handshake, holding buffer and frame load.
  always_comb begin
    buf_full_d    = buf_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    accept        = smp.sample_valid & ~buf_full_q;
    load_l        = '0;
    load_r        = '0;
    // A sample accepted on the load edge bypasses the buffer into the new frame.
    if (buf_full_q) begin
      load_l = buf_l_q;
      load_r = buf_r_q;
    end else if (accept) begin
      load_l = smp.sample_l;
      load_r = smp.sample_r;
    end
    frame_start_d = wrap;
    underrun_d    = wrap & ~buf_full_q & ~accept;
    if (wrap) begin
      act_l_d    = load_l;
      act_r_d    = load_r;
      buf_full_d = 1'b0;
    end else if (accept) begin
      buf_l_d    = smp.sample_l;
      buf_r_d    = smp.sample_r;
      buf_full_d = 1'b1;
    end
  end

  // Serial data for position b_next. On the load edge the new frame is not yet
  // registered, so the bit is taken from the frame being loaded.
  always_comb begin
    src_l    = wrap ? load_l : act_l_q;
    src_r    = wrap ? load_r : act_r_q;
    next_bit = 1'b0;
`ifdef I2S_TX_LJ_EN
    idx_l    = C_SB - C_ONE - b_ext;
    idx_r    = C_SLOT + C_SB - C_ONE - b_ext;
    bit_l    = |(src_l & (LSB_ONE << idx_l));
    bit_r    = |(src_r & (LSB_ONE << idx_r));
    if (b_ext < C_SB) begin
      next_bit = bit_l;
    end else if ((b_ext >= C_SLOT) && (b_ext < C_SLOT + C_SB)) begin
      next_bit = bit_r;
    end
`else
    idx_l    = C_SB - b_ext;
    idx_r    = C_SLOT + C_SB - b_ext;
    bit_l    = |(src_l & (LSB_ONE << idx_l));
    bit_r    = |(src_r & (LSB_ONE << idx_r));
    if ((b_ext >= C_ONE) && (b_ext <= C_SB)) begin
      next_bit = bit_l;
    end else if ((b_ext > C_SLOT) && (b_ext <= C_SLOT + C_SB)) begin
      next_bit = bit_r;
    end else if ((b_ext == '0) && (SAMPLE_BITS == SLOT_BITS)) begin
      // Full-width slot: the one-bit delay pushes the outgoing right LSB into b=0.
      next_bit = act_r_q[0];
    end
`endif
    sd_d = fall ? next_bit : sd_q;
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      sclk_q        <= 1'b0;
      ws_q          <= 1'b1;
      sd_q          <= 1'b0;
      b_q           <= B_LAST;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      sclk_q        <= sclk_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      b_q           <= b_d;
      buf_full_q    <= buf_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign dac_mclk         = input_clk;
  assign serial_clk       = sclk_q;
  assign word_select      = ws_q;
  assign sound_bit_out    = sd_q;
  assign bit_counter      = b_q;
  assign frame_start      = frame_start_q;
  assign underrun         = underrun_q;
  assign smp.sample_ready = ~buf_full_q;

endmodule
